// File: rtl/kronos_scoreboard_hcu_pkg.sv
// Shared types and default sizing for the Kronos scoreboard hazard control unit.
package kronos_scoreboard_hcu_pkg;

  // Number of architectural registers tracked (x0 is never tracked).
  localparam int HCU_NREG   = 32;
  // Maximum number of outstanding writes across the whole pipeline.
  localparam int HCU_DEPTH  = 4;
  // Width of each per-register outstanding-write counter.
  localparam int HCU_CW     = 2;
  // Same-cycle writeback clears a RAW hazard on the last claim when set.
  localparam int HCU_BYPASS = 1;

  // Architectural register index.
  typedef logic [4:0] regidx_t;

endpackage

// File: rtl/kronos_scoreboard_hcu_cnt.sv
// Saturating up/down claim counter: one increment and up to two decrements per cycle.
// Decrements are applied first and clamped at zero; the increment is dropped when it
// would push the count past MAX. 'over' reports that an increment this cycle would not
// fit, independent of whether one is requested, so the owner can veto an issue early.
module kronos_hcu_cnt
  import kronos_scoreboard_hcu_pkg::*;
#(
  parameter int W   = HCU_CW,
  parameter int MAX = (1 << HCU_CW) - 1
) (
  input  logic         clk,
  input  logic         rstz,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec1,
  input  logic         dec2,
  output logic [W-1:0] count,
  output logic         nonzero,
  output logic         full,
  output logic         under,
  output logic         over
);

  logic [W-1:0] r_count;
  logic [W:0]   w_cur;
  logic [W:0]   w_decReq;
  logic [W:0]   w_decApplied;
  logic [W:0]   w_afterDec;
  logic [W-1:0] w_next;

  // Net effect of this cycle's releases and claim, with underflow clamping and overflow veto.
  always_comb begin
    w_cur        = {1'b0, r_count};
    w_decReq     = (W+1)'(dec1) + (W+1)'(dec2);
    w_decApplied = (w_decReq > w_cur) ? w_cur : w_decReq;
    w_afterDec   = w_cur - w_decApplied;
    under        = (w_decReq > w_cur);
    over         = (w_afterDec >= (W+1)'(MAX));
    w_next       = w_afterDec[W-1:0] + W'(inc & ~over);
  end

  // Count register; a flush wins over any same-cycle claim or release.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else begin
      r_count <= w_next;
    end
  end

  assign count   = r_count;
  assign nonzero = (r_count != '0);
  assign full    = (r_count == W'(MAX));

endmodule

// File: rtl/kronos_scoreboard_hcu.sv
// Scoreboard hazard control unit: per-register outstanding-write counters plus a
// global in-flight window counter, producing a zero-latency decode stall.
module kronos_scoreboard_hcu
  import kronos_scoreboard_hcu_pkg::*;
#(
  parameter int NREG   = HCU_NREG,
  parameter int CW     = HCU_CW,
  parameter int DEPTH  = HCU_DEPTH,
  parameter int BYPASS = HCU_BYPASS
) (
  input  logic                       clk,
  input  logic                       rstz,
  input  logic                       clear,
  input  logic [$clog2(NREG)-1:0]    dec_rs1,
  input  logic [$clog2(NREG)-1:0]    dec_rs2,
  input  logic                       dec_rs1_en,
  input  logic                       dec_rs2_en,
  input  logic [$clog2(NREG)-1:0]    dec_rd,
  input  logic                       dec_rd_en,
  input  logic                       issue_vld,
  input  logic                       issue_rdy,
  input  logic                       wb_en,
  input  logic [$clog2(NREG)-1:0]    wb_sel,
  input  logic                       kill_en,
  input  logic [$clog2(NREG)-1:0]    kill_sel,
  output logic                       stall,
  output logic [NREG-1:0]            busy,
  output logic [$clog2(DEPTH+1)-1:0] inflight,
  output logic                       err
);

  localparam int IW   = $clog2(NREG);
  localparam int IFW  = $clog2(DEPTH + 1);
  localparam int CMAX = (1 << CW) - 1;

  logic [CW-1:0]  w_cnt [NREG];
  logic [NREG-1:0] w_busy;
  logic [NREG-1:0] w_full;
  logic [NREG-1:0] w_over;
  logic [NREG-1:0] w_under;

  logic           w_issueReq;
  logic           w_incOk;
  logic           w_wbReq;
  logic           w_killReq;
  logic           w_wbOk;
  logic           w_killOk;
  logic [IFW-1:0] w_inflight;
  logic           w_winFull;
  logic           w_winOver;
  logic           w_winUnder;
  logic           w_unusedWinNonzero;
  logic           w_raw1;
  logic           w_raw2;
  logic           w_waw;
  logic           w_window;
  logic           w_stall;
  logic           r_err;

  // x0 has no counter: it reads as permanently idle.
  assign w_cnt[0]   = '0;
  assign w_busy[0]  = 1'b0;
  assign w_full[0]  = 1'b0;
  assign w_over[0]  = 1'b0;
  assign w_under[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_reg
    kronos_hcu_cnt #(
      .W   (CW),
      .MAX (CMAX)
    ) u_cnt (
      .clk     (clk),
      .rstz    (rstz),
      .clr     (clear),
      .inc     (w_incOk && (dec_rd == IW'(r))),
      .dec1    (w_wbReq && (wb_sel == IW'(r))),
      .dec2    (w_killReq && (kill_sel == IW'(r))),
      .count   (w_cnt[r]),
      .nonzero (w_busy[r]),
      .full    (w_full[r]),
      .under   (w_under[r]),
      .over    (w_over[r])
    );
  end

  // Window counter only follows releases that actually retire a claim.
  kronos_hcu_cnt #(
    .W   (IFW),
    .MAX (DEPTH)
  ) u_window (
    .clk     (clk),
    .rstz    (rstz),
    .clr     (clear),
    .inc     (w_incOk),
    .dec1    (w_wbOk),
    .dec2    (w_killOk),
    .count   (w_inflight),
    .nonzero (w_unusedWinNonzero),
    .full    (w_winFull),
    .under   (w_winUnder),
    .over    (w_winOver)
  );

  // Claim/release requests and which releases find a live claim to retire.
  always_comb begin
    w_issueReq = issue_vld && issue_rdy && !w_stall && dec_rd_en && (dec_rd != '0);
    w_incOk    = w_issueReq && !w_over[dec_rd] && !w_winOver;
    w_wbReq    = wb_en && (wb_sel != '0);
    w_killReq  = kill_en && (kill_sel != '0);
    w_wbOk     = w_wbReq && (w_cnt[wb_sel] != '0);
    if (w_wbReq && (kill_sel == wb_sel)) begin
      w_killOk = w_killReq && (w_cnt[kill_sel] > CW'(1));
    end else begin
      w_killOk = w_killReq && (w_cnt[kill_sel] != '0);
    end
  end

  // Hazard detection; writeback bypass only relaxes RAW on a register's last claim.
  always_comb begin
    w_raw1 = dec_rs1_en && (dec_rs1 != '0) && w_busy[dec_rs1] &&
             !((BYPASS != 0) && wb_en && (wb_sel == dec_rs1) && (w_cnt[dec_rs1] == CW'(1)));
    w_raw2 = dec_rs2_en && (dec_rs2 != '0) && w_busy[dec_rs2] &&
             !((BYPASS != 0) && wb_en && (wb_sel == dec_rs2) && (w_cnt[dec_rs2] == CW'(1)));
    w_waw    = dec_rd_en && w_full[dec_rd];
    w_window = dec_rd_en && w_winFull;
    w_stall  = !clear && issue_vld && (w_raw1 || w_raw2 || w_waw || w_window);
  end

  // Sticky error on any release without a claim or any claim that could not be recorded.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      r_err <= 1'b0;
    end else if (!clear && ((|w_under) || w_winUnder ||
                            (w_issueReq && (w_over[dec_rd] || w_winOver)))) begin
      r_err <= 1'b1;
    end
  end

  assign stall    = w_stall;
  assign busy     = w_busy;
  assign inflight = w_inflight;
  assign err      = r_err;

endmodule

// File: doc/kronos_scoreboard_hcu.md
Name: kronos_scoreboard_hcu

Overview:
- Parametrised scoreboard hazard control unit for the Kronos pipeline. It replaces single-entry pending-write tracking with a per-register outstanding-write counter, so several writes can be in flight, including more than one to the same register.
- Sits beside decode:
  - records a destination claim when an instruction issues;
  - releases the claim on register writeback or on squash.
- Asserts stall for RAW hazards, WAW counter saturation, or a full in-flight window, with optional same-cycle writeback bypass.

Parameters:
- NREG, 32: number of architectural registers; x0 is never tracked.
- CW, 2: per-register counter width; max outstanding writes per register is 2**CW-1.
- DEPTH, 4: max total outstanding writes across all registers.
- BYPASS, 1: 1 = a writeback releasing the last claim on a source clears that hazard in the same cycle.

Ports:
- clk  in  1  core clock
- rstz  in  1  asynchronous active-low reset
- clear  in  1  synchronous pipeline flush; zeroes all counters
- dec_rs1  in  $clog2(NREG)  decode source 1 index
- dec_rs2  in  $clog2(NREG)  decode source 2 index
- dec_rs1_en  in  1  source 1 is read
- dec_rs2_en  in  1  source 2 is read
- dec_rd  in  $clog2(NREG)  decode destination index
- dec_rd_en  in  1  instruction writes rd
- issue_vld  in  1  decode valid
- issue_rdy  in  1  downstream ready; issue fires when vld&rdy&~stall
- wb_en  in  1  register writeback this cycle
- wb_sel  in  $clog2(NREG)  writeback register
- kill_en  in  1  in-flight instruction squashed; release its claim
- kill_sel  in  $clog2(NREG)  squashed instruction's rd
- stall  out  1  hold decode
- busy  out  NREG  bit r = cnt[r]!=0; bit 0 is always 0
- inflight  out  $clog2(DEPTH+1)  total outstanding claims
- err  out  1  sticky: underflow or overflow attempted

Behaviour:
- Reset (rstz low, async): every cnt[r]=0, inflight=0, err=0. Consequently stall=0 and busy=0.
- Issue event (inc):
  - fires when issue_vld & issue_rdy & ~stall & dec_rd_en & dec_rd!=0;
  - cnt[dec_rd]+1 and inflight+1 on the next edge.
- Release event (dec):
  - fires for each of wb_en (wb_sel!=0) and kill_en (kill_sel!=0);
  - cnt[sel]-1 and inflight-1 per release.
  - Both releases may hit the same register in one cycle: net -2.
- Simultaneous inc and dec on the same register: the net is applied, so the counter is unchanged for +1-1.
- Underflow:
  - a release on a register with cnt=0 is ignored;
  - err sets, and stays set until reset.
- Overflow:
  - an inc that would exceed 2**CW-1 or DEPTH cannot occur when stall is honoured;
  - if forced (issue ignoring stall), the inc is dropped and err sets.
- clear:
  - all counters and inflight go to 0 next edge;
  - it overrides any same-cycle inc/dec;
  - err is unaffected.
- RAW hazard on source s:
  - condition: dec_rsX_en & rsX!=0 & cnt[rsX]!=0;
  - with BYPASS=1 it is masked when wb_en & wb_sel==rsX & cnt[rsX]==1.
- WAW stall: dec_rd_en & cnt[dec_rd]==2**CW-1.
- Window stall: dec_rd_en & inflight==DEPTH. The bypass rule does not apply to window or WAW stalls.
- stall:
  - equals (raw1|raw2|waw|window) & issue_vld;
  - purely combinational from current state and inputs, zero-latency;
  - no stall while clear is high.
- Claim visibility: a claim made at issue on edge N is visible in busy/stall from cycle N+1.

Decomposition:
- kronos_types additions:
  - HCU_NREG and HCU_DEPTH defaults;
  - a typedef for a register index: logic [4:0] regidx_t.
- One natural sub-module, kronos_hcu_cnt: a single saturating up/down counter cell holding one register's claim count.
  - Inputs: inc, dec1, dec2, clr.
  - Outputs: count, nonzero, full, under, over.
  - Instanced NREG-1 times. The window counter reuses the same cell with a wider width.

Test Plan:
- Reset mid-operation: cnt[5]=2, rstz pulsed low between edges -> busy=0 and inflight=0 immediately, stall=0.
- RAW with bypass: issue rd=3; next instr rs1=3 -> stall=1. Assert wb_en with wb_sel=3 in that cycle -> stall=0 (BYPASS=1); with BYPASS=0 stall=1 until the cycle after writeback.
- Double claim: issue rd=7 twice, wb to 7 once -> busy[7]=1 and inflight=1. Second wb -> busy[7]=0.
- WAW saturation: CW=2, three issues to rd=9 -> a fourth rd=9 issue sees stall=1; it issues the cycle after any wb_sel=9.
- Window full: DEPTH=4, issue rd=1..4 -> inflight=4 and rd=5 issue stalls. The same stall holds for a non-writing instr with a hazard-free source? No: dec_rd_en=0 -> no stall.
- Kill, x0 and underflow: issue rd=2, kill_sel=2 and wb_sel=0 same cycle -> cnt[2]=0, x0 untracked. Then wb_sel=2 -> err=1, counters unchanged. Then clear with a same-cycle issue -> all counters 0.
